apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
- APB completer (responder) for the timer slot at 0x4001_1000–0x4001_1FFF; driven by the AHB-to-APB bridge's `psel_s2`, `paddr`, `pwrite`, `pwdata` and `penable`, and returns `prdata_s2`.
- Provides a 32-bit down-counter with 8-bit prescaler, one-shot/periodic modes, a sticky expiry flag and a level interrupt to the core.
- APB3 subset only: no PREADY and no PSLVERR. Every access completes in exactly setup + access (2 cycles).

Parameters:
- PRESCALE_W, 8: width of the prescaler field and prescaler counter.
- LOAD_RST, 32'h0000_0000: reset value of the LOAD register.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  slave select, already address-decoded by the bridge.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address; only paddr[11:0] is used.
- pwdata  in  32  write data.
- prdata  out  32  read data; valid throughout the access phase.
- irq  out  1  level interrupt = STATUS.FLAG & CTRL.IE.

Behaviour:
- Register map, at offset paddr[11:0]; word accesses only, paddr[1:0] ignored:
  - 0x000 CTRL (RW): [0] EN, [1] PERIODIC, [2] IE, [15:8] PRESCALE; all other bits read 0.
  - 0x004 LOAD (RW, 32 bits): reload value.
  - 0x008 VALUE (RO): current count; writes ignored.
  - 0x00C STATUS: [0] FLAG; write 1 clears (W1C), write 0 has no effect.
  - Any other offset reads 0x0 and ignores writes.
- APB timing:
  - Setup phase = psel & !penable. On a read setup, prdata is registered from the addressed register.
  - prdata is held stable through the access cycle and afterwards until the next read setup.
  - Writes commit on the edge ending the access phase (psel & penable & pwrite).
  - Back-to-back transfers with no idle cycle between them are legal.
  - The penable & !psel combination is ignored.
- Reset (rst=1 at a clock edge) sets:
  - CTRL=0, LOAD=LOAD_RST, VALUE=0, FLAG=0, prescaler count=0, prdata=0, irq=0.
  - Reset mid-transfer abandons the transfer; nothing is committed.
- Counter states:
  - STOPPED (EN=0): VALUE and the prescaler hold.
  - RUNNING (EN=1).
- STOPPED -> RUNNING: a CTRL write with EN going 0->1. In that same edge, VALUE<=LOAD and the prescaler count<=0.
- CTRL writes that keep EN=1 update PERIODIC, IE and PRESCALE without reloading or resetting the prescaler.
- CTRL write with EN=0: goes to STOPPED immediately; VALUE freezes.
- Tick: in RUNNING, the prescaler counts 0..PRESCALE, then wraps to 0. A tick is the cycle with count==PRESCALE, so the tick period is PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
- On a tick with VALUE!=0: VALUE<=VALUE-1.
- On a tick with VALUE==0 (expiry): FLAG<=1, and then:
  - PERIODIC=1: VALUE<=LOAD (the current LOAD).
  - PERIODIC=0: EN<=0, VALUE stays 0.
- Expiry period from enable = (LOAD+1)*(PRESCALE+1) cycles. LOAD=0 in periodic mode expires on every tick.
- A LOAD write while RUNNING does not change VALUE; it takes effect at the next reload or enable.
- irq is combinational from registered FLAG and IE, so it asserts the cycle after the expiry edge.
- Simultaneous events:
  - Expiry and a W1C of FLAG on the same edge: the set wins, FLAG=1.
  - Expiry and a CTRL write on the same edge: the CTRL write wins for EN; the one-shot auto-clear is overridden if software writes EN=1.
  - Expiry and an EN 0->1 restart on the same edge: the restart wins for VALUE.
- A read of VALUE samples the value at setup; a decrement during the access phase is not reflected.

Test Plan:
- Reset, then read all four offsets plus 0x010 -> every read returns 0x0 and irq=0; a write to VALUE of 0x1234 reads back 0x0.
- LOAD=3, CTRL=0x0000_0007 (EN, PERIODIC, IE, PRESCALE=0) -> VALUE sequence 3,2,1,0,3,...; FLAG sets every 4 cycles and irq rises the cycle after the expiry edge; writing STATUS=1 drops irq.
- LOAD=1, CTRL=0x0000_0201 (one-shot, PRESCALE=2) -> expiry 6 cycles after the enabling edge; CTRL reads 0x0000_0200 afterwards, VALUE=0, FLAG=1, irq=0 since IE=0.
- Running periodic with LOAD=5, write LOAD=9 mid-count -> the current period still ends from 5; the next reload is 9.
- Force a W1C of STATUS on the expiry edge -> FLAG reads 1 afterwards.
- Assert rst during the access phase of a CTRL=0x1 write -> CTRL=0 and the timer does not start.

Source files
------------

// File: rtl/apb_timer.sv
// APB3-subset timer completer: 32-bit down-counter with prescaler, one-shot or
// periodic reload, sticky expiry flag and a level interrupt.
module apb_timer #(
   parameter int unsigned PRESCALE_W = 8,
   parameter logic [31:0] LOAD_RST   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        irq
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OFF_W  = 10;
   localparam int unsigned PS_LSB = 8;

   localparam logic [OFF_W-1:0] OFF_CTRL   = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_LOAD   = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_VALUE  = OFF_W'(2);
   localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(3);

   typedef enum logic {
      ST_STOPPED = 1'b0,
      ST_RUNNING = 1'b1
   } state_t;

   state_t                  state,    state_nxt;
   logic                    periodic, periodic_nxt;
   logic                    ie,       ie_nxt;
   logic [PRESCALE_W-1:0]   prescale, prescale_nxt;
   logic [PRESCALE_W-1:0]   pcount,   pcount_nxt;
   logic [DATA_W-1:0]       load,     load_nxt;
   logic [DATA_W-1:0]       value,    value_nxt;
   logic                    flag,     flag_nxt;
   logic [DATA_W-1:0]       prdata_nxt;

   logic                    wr_access;
   logic                    rd_setup;
   logic [OFF_W-1:0]        off;
   logic                    running;
   logic                    tick;
   logic                    expire;
   logic [DATA_W-1:0]       rd_data;
   logic                    unused_addr;

   // Only the word offset inside the 4 KiB slot selects a register.
   assign off         = paddr[11:2];
   assign unused_addr = ^{paddr[31:12], paddr[1:0]};

   // Transfer decode and tick generation; tick fires once the prescaler has
   // reached PRESCALE so that shrinking PRESCALE mid-count cannot stall it.
   always_comb begin
      wr_access = psel & penable & pwrite;
      rd_setup  = psel & ~penable & ~pwrite;
      running   = (state == ST_RUNNING);
      tick      = running && (pcount >= prescale);
      expire    = tick && (value == '0);
   end

   // Register read mux, sampled on a read setup.
   always_comb begin
      rd_data = '0;
      case (off)
         OFF_CTRL: begin
            rd_data[0]                   = running;
            rd_data[1]                   = periodic;
            rd_data[2]                   = ie;
            rd_data[PS_LSB +: PRESCALE_W] = prescale;
         end
         OFF_LOAD:   rd_data = load;
         OFF_VALUE:  rd_data = value;
         OFF_STATUS: rd_data[0] = flag;
         default:    rd_data = '0;
      endcase
   end

   // State register with synchronous reset; an abandoned transfer commits nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_STOPPED;
         periodic <= 1'b0;
         ie       <= 1'b0;
         prescale <= '0;
         pcount   <= '0;
         load     <= LOAD_RST;
         value    <= '0;
         flag     <= 1'b0;
         prdata   <= '0;
      end else begin
         state    <= state_nxt;
         periodic <= periodic_nxt;
         ie       <= ie_nxt;
         prescale <= prescale_nxt;
         pcount   <= pcount_nxt;
         load     <= load_nxt;
         value    <= value_nxt;
         flag     <= flag_nxt;
         prdata   <= prdata_nxt;
      end
   end

   // Next-state: counting first, then software writes override, then expiry
   // sets FLAG last so it beats a same-edge W1C.
   always_comb begin
      state_nxt    = state;
      periodic_nxt = periodic;
      ie_nxt       = ie;
      prescale_nxt = prescale;
      pcount_nxt   = pcount;
      load_nxt     = load;
      value_nxt    = value;
      flag_nxt     = flag;
      prdata_nxt   = prdata;

      if (running) begin
         pcount_nxt = tick ? '0 : pcount + PRESCALE_W'(1);
         if (tick) begin
            if (value != '0) begin
               value_nxt = value - DATA_W'(1);
            end else if (periodic) begin
               value_nxt = load;
            end else begin
               state_nxt = ST_STOPPED;
            end
         end
      end

      if (wr_access) begin
         case (off)
            OFF_CTRL: begin
               periodic_nxt = pwdata[1];
               ie_nxt       = pwdata[2];
               prescale_nxt = pwdata[PS_LSB +: PRESCALE_W];
               if (pwdata[0]) begin
                  state_nxt = ST_RUNNING;
                  if (!running) begin
                     value_nxt  = load;
                     pcount_nxt = '0;
                  end
               end else begin
                  state_nxt = ST_STOPPED;
               end
            end
            OFF_LOAD: load_nxt = pwdata;
            OFF_STATUS: begin
               if (pwdata[0]) begin
                  flag_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end

      if (expire) begin
         flag_nxt = 1'b1;
      end

      if (rd_setup) begin
         prdata_nxt = rd_data;
      end
   end

   assign irq = flag & ie;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed scenarios plus random APB traffic
// compared every cycle against a behavioural model of the timer.
module tb_apb_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   bit        m_en, m_per, m_ie, m_flag;
   bit [7:0]  m_pre, m_cnt;
   bit [31:0] m_load, m_val, m_prd;

   apb_timer #(.PRESCALE_W(8), .LOAD_RST(32'h0000_0000)) dut (
      .clk     (clk),
      .rst     (rst),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit [31:0] m_read(input bit [31:0] a);
      case (a[11:0] & 12'hFFC)
         12'h000: return {16'h0, m_pre, 5'h0, m_ie, m_per, m_en};
         12'h004: return m_load;
         12'h008: return m_val;
         12'h00C: return {31'h0, m_flag};
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge of the timer's rules, applied to the inputs present at the edge.
   task automatic model_edge();
      bit        wr, tick, expire;
      bit [11:0] off;
      bit        n_en, n_per, n_ie, n_flag;
      bit [7:0]  n_pre, n_cnt;
      bit [31:0] n_load, n_val, n_prd;
      if (rst) begin
         {m_en, m_per, m_ie, m_flag} = 4'b0;
         m_pre = 0; m_cnt = 0; m_load = 32'h0; m_val = 0; m_prd = 0;
         return;
      end
      wr  = psel && penable && pwrite;
      off = paddr[11:0] & 12'hFFC;
      n_en = m_en; n_per = m_per; n_ie = m_ie; n_flag = m_flag;
      n_pre = m_pre; n_cnt = m_cnt; n_load = m_load; n_val = m_val; n_prd = m_prd;
      if (psel && !penable && !pwrite) n_prd = m_read(paddr);
      tick   = m_en && (m_cnt >= m_pre);
      expire = tick && (m_val == 0);
      if (m_en) n_cnt = tick ? 8'd0 : m_cnt + 8'd1;
      if (tick && !expire) n_val = m_val - 1;
      if (expire && m_per) n_val = m_load;
      if (expire && !m_per) n_en = 0;
      if (wr && off == 12'h000) begin
         n_en = pwdata[0]; n_per = pwdata[1]; n_ie = pwdata[2]; n_pre = pwdata[15:8];
         if (pwdata[0] && !m_en) begin
            n_val = m_load;
            n_cnt = 0;
         end
      end
      if (wr && off == 12'h004) n_load = pwdata;
      if (wr && off == 12'h00C && pwdata[0]) n_flag = 0;
      if (expire) n_flag = 1;
      m_en = n_en; m_per = n_per; m_ie = n_ie; m_flag = n_flag;
      m_pre = n_pre; m_cnt = n_cnt; m_load = n_load; m_val = n_val; m_prd = n_prd;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("irq", 32'(irq), 32'(m_flag & m_ie));
      check("prdata", prdata, m_prd);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      step();
      penable = 1'b1;
      step();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = $urandom;
      step();
      penable = 1'b1;
      step();
      d = prdata;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, d, a;
      psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;

      // Reset state of every register and an unmapped offset
      for (int i = 0; i < 5; i++) begin
         apb_read(32'h4001_1000 + 32'(4 * i), rd);
         check("reset_read", rd, 32'h0);
      end
      check("reset_irq", 32'(irq), 32'h0);
      apb_write(32'h4001_1008, 32'h1234);
      apb_read(32'h4001_1008, rd);
      check("value_ro", rd, 32'h0);

      // Periodic, PRESCALE=0, LOAD=3: expiry every 4 cycles
      apb_write(32'h4001_1004, 32'd3);
      apb_write(32'h4001_1000, 32'h0000_0007);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("irq_rise", 32'(irq), (k == 4) ? 32'h1 : 32'h0);
      end
      apb_write(32'h4001_100C, 32'h1);
      check("irq_w1c", 32'(irq), 32'h0);
      apb_read(32'h4001_1008, rd); check("value_seq0", rd, 32'd1);
      apb_read(32'h4001_1008, rd); check("value_seq1", rd, 32'd3);
      apb_read(32'h4001_1008, rd); check("value_seq2", rd, 32'd1);
      apb_write(32'h4001_1000, 32'h0);

      // One-shot, PRESCALE=2, LOAD=1: expires on the 6th edge after enable
      apb_write(32'h4001_100C, 32'h1);
      apb_write(32'h4001_1004, 32'd1);
      apb_write(32'h4001_1000, 32'h0000_0201);
      idle(5);
      apb_read(32'h4001_100C, rd); check("oneshot_before", rd, 32'h0);
      apb_read(32'h4001_100C, rd); check("oneshot_flag", rd, 32'h1);
      apb_read(32'h4001_1000, rd); check("oneshot_ctrl", rd, 32'h0000_0200);
      apb_read(32'h4001_1008, rd); check("oneshot_value", rd, 32'h0);
      check("oneshot_irq", 32'(irq), 32'h0);

      // LOAD rewrite mid-count only affects the next reload
      apb_write(32'h4001_100C, 32'h1);
      apb_write(32'h4001_1004, 32'd5);
      apb_write(32'h4001_1000, 32'h0000_0003);
      apb_write(32'h4001_1004, 32'd9);
      idle(3);
      apb_read(32'h4001_1008, rd); check("reload_old", rd, 32'd0);
      apb_read(32'h4001_1008, rd); check("reload_new", rd, 32'd8);
      apb_read(32'h4001_100C, rd); check("reload_flag", rd, 32'h1);
      apb_write(32'h4001_1000, 32'h0);

      // W1C on the expiry edge: set wins
      apb_write(32'h4001_100C, 32'h1);
      apb_write(32'h4001_1004, 32'd3);
      apb_write(32'h4001_1000, 32'h0000_0003);
      idle(2);
      apb_write(32'h4001_100C, 32'h1);
      apb_read(32'h4001_100C, rd); check("w1c_vs_set", rd, 32'h1);
      apb_write(32'h4001_1000, 32'h0);

      // Reset during the access phase of an enabling CTRL write
      apb_write(32'h4001_1004, 32'd7);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4001_1000; pwdata = 32'h1;
      step();
      penable = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      idle(3);
      apb_read(32'h4001_1000, rd); check("rst_mid_ctrl", rd, 32'h0);
      apb_read(32'h4001_1008, rd); check("rst_mid_value", rd, 32'h0);
      apb_read(32'h4001_1004, rd); check("rst_mid_load", rd, 32'h0);

      // Random traffic, including back-to-back transfers and stray penable
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         case ($urandom_range(0, 9))
            0, 1: begin
               d = $urandom;
               d[15:8] = 8'($urandom_range(0, 3));
               d[0] = ($urandom_range(0, 3) != 0);
               a[11:0] = 12'h000 | 12'($urandom_range(0, 3));
               apb_write(a, d);
            end
            2: begin
               a[11:0] = 12'h004;
               apb_write(a, 32'($urandom_range(0, 12)));
            end
            3: begin
               a[11:0] = 12'h00C;
               apb_write(a, $urandom);
            end
            4: begin
               a[11:0] = ($urandom_range(0, 1) == 0) ? 12'h008
                         : 12'(16 + 4 * $urandom_range(0, 1019));
               apb_write(a, $urandom);
            end
            5, 6, 7: begin
               a[11:0] = 12'(4 * $urandom_range(0, 7)) | 12'($urandom_range(0, 3));
               apb_read(a, rd);
            end
            8: idle($urandom_range(1, 6));
            default: begin
               psel = 1'b0; penable = 1'b1; pwrite = 1'($urandom_range(0, 1));
               paddr = a; pwdata = $urandom;
               step();
               penable = 1'b0;
            end
         endcase
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
